uart_rx_frame: RTL and testbench
================================

Name: uart_rx_frame

Overview:
- Receive-framing stage for an asynchronous 8N1 serial link.
- Sits directly beside an external flex_counter used as its bit timer, with `NUM_CNT_BITS = TIMER_BITS`:
  - drives the timer's `clear`, `count_enable` and `rollover_val`;
  - consumes the timer's `rollover_flag` as its sample strobe.
- Detects the start bit, samples each data bit at mid-bit and checks the stop bit.
- Presents each received byte on a valid/ready output buffer, with error pulses.

Parameters:
- CLKS_PER_BIT, 16, clocks per serial bit; must be even, at least 4 and at most 2^TIMER_BITS-1.
- TIMER_BITS, 5, width of the timer rollover value.
- DATA_BITS, 8, data bits per frame, LSB first.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- serial_in  in  1  asynchronous serial line; idles high.
- tmr_clear  out  1  timer clear pulse.
- tmr_enable  out  1  timer count enable.
- tmr_rollover_val  out  TIMER_BITS  timer terminal count.
- tmr_rollover_flag  in  1  timer rollover flag; registered, high in the cycle the timer count equals tmr_rollover_val.
- rx_data  out  DATA_BITS  received byte; stable while rx_valid is high.
- rx_valid  out  1  output buffer full.
- rx_ready  in  1  consumer accepts; transfer occurs when rx_valid & rx_ready at a rising edge.
- framing_error  out  1  one-cycle pulse: stop bit sampled 0.
- overrun_error  out  1  one-cycle pulse: good frame dropped because the buffer was full.

Behaviour:
- Reset values:
  - FSM in IDLE.
  - Synchronizer flops and edge-history flop = 1.
  - Shift register, bit index, rx_data = 0.
  - rx_valid, framing_error, overrun_error, tmr_clear, tmr_enable = 0.
  - tmr_rollover_val = CLKS_PER_BIT/2.
- Reset mid-frame abandons the frame with no error pulse.
- serial_in passes through a 2-flop synchronizer (reset high). The falling edge is (prev == 1 && sync == 0).
- Timer contract: after tmr_clear in cycle t with enable held, the flag is seen high N cycles later (N = tmr_rollover_val). The timer then wraps to 1 and flags every N cycles. The FSM acts only on the flag while tmr_enable = 1.
- tmr_rollover_val is combinational from state: CLKS_PER_BIT/2 in IDLE/START, CLKS_PER_BIT otherwise.
- tmr_enable = 1 in START, DATA and STOP.
- FSM states IDLE, START, DATA, STOP, LOAD:
  - IDLE: on falling edge, assert tmr_clear and go to START.
  - START: on flag, sample sync.
    - Sample 0: assert tmr_clear, bit index = 0, go to DATA.
    - Sample 1 (glitch): go to IDLE silently.
  - DATA: on flag, shift sync in at the MSB (right shift, LSB first) and increment the bit index. The DATA_BITS-th sample goes to STOP. No re-clear of the timer.
  - STOP: on flag, latch the stop sample and go to LOAD.
  - LOAD (one cycle, then IDLE):
    - Stop = 0: pulse framing_error, drop data.
    - Stop = 1 and buffer free (rx_valid = 0, or rx_ready = 1 this cycle): rx_data <= shift, rx_valid <= 1.
    - Stop = 1 and buffer full (rx_valid = 1 and rx_ready = 0): pulse overrun_error; rx_data is unchanged.
- A transfer with no simultaneous load clears rx_valid next cycle.
- Falling edges outside IDLE are ignored. A new start edge is detected from the first IDLE cycle onward.
- Latency (CLKS_PER_BIT = 16, DATA_BITS = 8): rx_valid rises 155 rising edges after the first edge that samples serial_in = 0.

Decomposition:
- Package uart_rx_pkg holds:
  - the state enum type (IDLE, START, DATA, STOP, LOAD);
  - localparam helpers for HALF_BIT and FULL_BIT derived from CLKS_PER_BIT;
  - the bit-index width via $clog2(DATA_BITS+1).
- One natural sub-module: rx_sync, a 2-flop synchronizer plus history flop, reset-to-1, with outputs sync and fall.
- The bench instantiates flex_counter externally and wires it to the tmr_* ports.

Test Plan:
- Frame 0xA5, stop bit 1, rx_ready = 0 -> rx_valid rises after 155 edges, rx_data = 0xA5, no error pulses; rx_valid and rx_data hold until rx_ready = 1, then rx_valid = 0 the next cycle.
- serial_in low for 3 cycles, then high -> FSM returns to IDLE after 9 cycles; tmr_enable back to 0; no rx_valid and no errors.
- Frame 0x3C with stop bit 0 -> one framing_error pulse in the cycle after LOAD; rx_valid stays 0; the next good frame 0x81 is received correctly.
- Frames 0x11 then 0x22 back-to-back with rx_ready = 0 -> rx_data = 0x11, one overrun_error pulse on the second frame, rx_valid stays 1.
- rx_valid = 1 holding 0x11, rx_ready = 1 exactly in the LOAD cycle of frame 0x22 -> rx_valid stays 1, rx_data = 0x22, no overrun_error.
- rst pulsed during DATA bit 4 -> all outputs at reset values the same cycle (asynchronous); a following frame 0xF0 is received as 0xF0.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared types and sizing helpers for the 8N1 receive-framing stage.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        LOAD
    } rx_state_e;

    localparam int DEF_CLKS_PER_BIT = 16;
    localparam int DEF_TIMER_BITS   = 5;
    localparam int DEF_DATA_BITS    = 8;

    // Half a bit period lands the first sample in the middle of the start bit.
    function automatic int half_bit(input int clks_per_bit);
        return clks_per_bit / 2;
    endfunction

    function automatic int full_bit(input int clks_per_bit);
        return clks_per_bit;
    endfunction

    // One extra count so the index can reach DATA_BITS itself.
    function automatic int idx_width(input int data_bits);
        return $clog2(data_bits + 1);
    endfunction

endpackage

// File: rtl/rx_sync.sv
// Two-flop synchronizer for the serial line plus a history flop for falling-edge detection.
module rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic sync,
    output logic fall
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic prev_q, prev_d;

    always_comb begin
        meta_d = async_in;
        sync_d = meta_q;
        prev_d = sync_q;
    end

    // Reset high so an idle line never looks like a start edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign sync = sync_q;
    assign fall = prev_q & ~sync_q;

endmodule

// File: rtl/uart_rx_frame.sv
// 8N1 receive framer: drives an external bit timer, samples mid-bit, checks the stop bit
// and hands bytes out through a one-entry valid/ready buffer with error pulses.
module uart_rx_frame
    import uart_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int TIMER_BITS   = DEF_TIMER_BITS,
    parameter int DATA_BITS    = DEF_DATA_BITS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  serial_in,
    output logic                  tmr_clear,
    output logic                  tmr_enable,
    output logic [TIMER_BITS-1:0] tmr_rollover_val,
    input  logic                  tmr_rollover_flag,
    output logic [DATA_BITS-1:0]  rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    output logic                  framing_error,
    output logic                  overrun_error
);

    localparam int HALF_BIT = half_bit(CLKS_PER_BIT);
    localparam int FULL_BIT = full_bit(CLKS_PER_BIT);
    localparam int IDX_W    = idx_width(DATA_BITS);

    localparam logic [TIMER_BITS-1:0] HALF_VAL = TIMER_BITS'(HALF_BIT);
    localparam logic [TIMER_BITS-1:0] FULL_VAL = TIMER_BITS'(FULL_BIT);
    localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(DATA_BITS - 1);

    rx_state_e            state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q,  data_d;
    logic [IDX_W-1:0]     idx_q,   idx_d;
    logic                 stop_q,  stop_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q,  ferr_d;
    logic                 oerr_q,  oerr_d;

    logic sync;
    logic fall;
    logic strobe;
    logic clear_c;

    rx_sync u_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (serial_in),
        .sync     (sync),
        .fall     (fall)
    );

    assign tmr_enable       = (state_q == START) || (state_q == DATA) || (state_q == STOP);
    assign tmr_rollover_val = ((state_q == IDLE) || (state_q == START)) ? HALF_VAL : FULL_VAL;
    // A stale flag left over from a previous frame must not advance the FSM.
    assign strobe           = tmr_rollover_flag & tmr_enable;

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        data_d  = data_q;
        idx_d   = idx_q;
        stop_d  = stop_q;
        valid_d = valid_q;
        ferr_d  = 1'b0;
        oerr_d  = 1'b0;
        clear_c = 1'b0;

        if (valid_q && rx_ready) begin
            valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (fall) begin
                    clear_c = 1'b1;
                    state_d = START;
                end
            end

            START: begin
                if (strobe) begin
                    if (!sync) begin
                        // Re-align the timer so data samples fall a full bit after mid-start.
                        clear_c = 1'b1;
                        idx_d   = '0;
                        state_d = DATA;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end

            DATA: begin
                if (strobe) begin
                    shift_d                = shift_q >> 1;
                    shift_d[DATA_BITS-1]   = sync;
                    idx_d                  = idx_q + IDX_W'(1);
                    if (idx_q == LAST_IDX) begin
                        state_d = STOP;
                    end
                end
            end

            STOP: begin
                if (strobe) begin
                    stop_d  = sync;
                    state_d = LOAD;
                end
            end

            LOAD: begin
                state_d = IDLE;
                if (!stop_q) begin
                    ferr_d = 1'b1;
                end else if (!valid_q || rx_ready) begin
                    data_d  = shift_q;
                    valid_d = 1'b1;
                end else begin
                    oerr_d = 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            shift_q <= '0;
            data_q  <= '0;
            idx_q   <= '0;
            stop_q  <= 1'b0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            oerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            idx_q   <= idx_d;
            stop_q  <= stop_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            oerr_q  <= oerr_d;
        end
    end

    assign tmr_clear     = clear_c;
    assign rx_data       = data_q;
    assign rx_valid      = valid_q;
    assign framing_error = ferr_q;
    assign overrun_error = oerr_q;

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame with a behavioural bit timer and a byte scoreboard.
module tb_uart_rx_frame;

    localparam int CPB   = 16;
    localparam int TBITS = 5;
    localparam int DBITS = 8;
    localparam int FRAME = 10 * CPB;

    logic             clk = 1'b0;
    logic             rst;
    logic             serial_in;
    logic             tmr_clear;
    logic             tmr_enable;
    logic [TBITS-1:0] tmr_rollover_val;
    logic             tmr_rollover_flag;
    logic [DBITS-1:0] rx_data;
    logic             rx_valid;
    logic             rx_ready;
    logic             framing_error;
    logic             overrun_error;

    int passed = 0;
    int total  = 0;
    int cyc    = 0;

    logic [7:0] exp_q[$];
    int frame_start_cyc = 0;
    int rise_cyc = 0;
    int ferr_cyc = 0;
    int oerr_cyc = 0;
    int ferr_cnt = 0;
    int oerr_cnt = 0;
    int items    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_rx_frame #(
        .CLKS_PER_BIT (CPB),
        .TIMER_BITS   (TBITS),
        .DATA_BITS    (DBITS)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .serial_in         (serial_in),
        .tmr_clear         (tmr_clear),
        .tmr_enable        (tmr_enable),
        .tmr_rollover_val  (tmr_rollover_val),
        .tmr_rollover_flag (tmr_rollover_flag),
        .rx_data           (rx_data),
        .rx_valid          (rx_valid),
        .rx_ready          (rx_ready),
        .framing_error     (framing_error),
        .overrun_error     (overrun_error)
    );

    // Bit timer: a clear restarts the count at 1, so the flag appears N cycles after the clear cycle.
    logic [TBITS-1:0] tcount;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            tcount            <= '0;
            tmr_rollover_flag <= 1'b0;
        end else if (tmr_clear) begin
            tcount            <= 5'd1;
            tmr_rollover_flag <= (tmr_rollover_val == 5'd1);
        end else if (tmr_enable) begin
            tcount            <= (tcount == tmr_rollover_val) ? 5'd1 : tcount + 5'd1;
            tmr_rollover_flag <= (tcount != tmr_rollover_val) && (tcount + 5'd1 == tmr_rollover_val);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drives one frame; stop_after < FRAME abandons it mid-way, ready_in_load raises rx_ready in the LOAD cycle.
    task automatic send_frame(input logic [7:0] d, input logic stop, input bit ready_in_load,
                              input int stop_after);
        int b;
        frame_start_cyc = cyc;
        for (int i = 0; i < stop_after; i++) begin
            b = i / CPB;
            if (b == 0)      serial_in = 1'b0;
            else if (b == 9) serial_in = stop;
            else             serial_in = d[b-1];
            if (ready_in_load) begin
                if (i == FRAME - 5)      rx_ready = 1'b1;
                else if (i == FRAME - 4) rx_ready = 1'b0;
            end
            step(1);
        end
    endtask

    // Output monitor: a new item is a valid beat that was empty or just accepted one cycle earlier.
    initial begin
        logic prev_valid;
        logic prev_ready;
        logic [31:0] e;
        prev_valid = 1'b0;
        prev_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_valid = 1'b0;
                prev_ready = 1'b0;
            end else begin
                if (framing_error) begin ferr_cnt++; ferr_cyc = cyc; end
                if (overrun_error) begin oerr_cnt++; oerr_cyc = cyc; end
                if (rx_valid && (!prev_valid || prev_ready)) begin
                    items++;
                    if (!prev_valid) rise_cyc = cyc;
                    if (exp_q.size() != 0) e = 32'(exp_q.pop_front());
                    else                   e = 'x;
                    $display("item %0d at cycle %0d: rx_data=%02h expected=%0h", items, cyc, rx_data, e);
                    check("rx_data", 32'(rx_data), e);
                end
                prev_valid = rx_valid;
                prev_ready = rx_ready;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int f0, o0, i0;

        rst = 1'b1;
        serial_in = 1'b1;
        rx_ready = 1'b0;
        step(3);
        check("rst_valid",   32'(rx_valid), 0);
        check("rst_data",    32'(rx_data), 0);
        check("rst_enable",  32'(tmr_enable), 0);
        check("rst_clear",   32'(tmr_clear), 0);
        check("rst_rollval", 32'(tmr_rollover_val), CPB / 2);
        check("rst_ferr",    32'(framing_error), 0);
        check("rst_oerr",    32'(overrun_error), 0);
        rst = 1'b0;
        step(10);

        // Good frame, consumer stalled
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1, 1'b0, FRAME);
        serial_in = 1'b1;
        check("latency", 32'(rise_cyc - frame_start_cyc - 1), 155);
        step(20);
        check("a5_hold_valid", 32'(rx_valid), 1);
        check("a5_hold_data",  32'(rx_data), 32'h A5);
        check("a5_no_ferr",    32'(ferr_cnt), 0);
        check("a5_no_oerr",    32'(oerr_cnt), 0);
        rx_ready = 1'b1;
        step(1);
        rx_ready = 1'b0;
        check("a5_accept_clears", 32'(rx_valid), 0);
        check("a5_sb_drained", 32'(exp_q.size()), 0);

        // Short glitch on the line
        f0 = ferr_cnt; o0 = oerr_cnt; i0 = items;
        step(5);
        serial_in = 1'b0;
        step(3);
        serial_in = 1'b1;
        check("glitch_in_start", 32'(tmr_enable), 1);
        step(7);
        check("glitch_still_start", 32'(tmr_enable), 1);
        step(1);
        check("glitch_back_idle", 32'(tmr_enable), 0);
        step(10);
        check("glitch_no_item",  32'(items), 32'(i0));
        check("glitch_no_valid", 32'(rx_valid), 0);
        check("glitch_no_err",   32'(ferr_cnt + oerr_cnt), 32'(f0 + o0));

        // Bad stop bit, then a good frame with the consumer ready
        f0 = ferr_cnt;
        send_frame(8'h3C, 1'b0, 1'b0, FRAME);
        serial_in = 1'b1;
        step(5);
        check("ferr_count", 32'(ferr_cnt), 32'(f0 + 1));
        check("ferr_timing", 32'(ferr_cyc - frame_start_cyc), 156);
        check("ferr_no_valid", 32'(rx_valid), 0);
        rx_ready = 1'b1;
        exp_q.push_back(8'h81);
        send_frame(8'h81, 1'b1, 1'b0, FRAME);
        serial_in = 1'b1;
        step(5);
        rx_ready = 1'b0;
        check("x81_sb_drained", 32'(exp_q.size()), 0);
        check("x81_ferr_once",  32'(ferr_cnt), 32'(f0 + 1));

        // Back-to-back frames into a full buffer
        o0 = oerr_cnt;
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1, 1'b0, FRAME);
        send_frame(8'h22, 1'b1, 1'b0, FRAME);
        serial_in = 1'b1;
        step(5);
        check("oerr_count",  32'(oerr_cnt), 32'(o0 + 1));
        check("oerr_timing", 32'(oerr_cyc - frame_start_cyc), 156);
        check("oerr_valid",  32'(rx_valid), 1);
        check("oerr_data",   32'(rx_data), 32'h11);

        // Consumer accepts exactly in the LOAD cycle of the next frame
        o0 = oerr_cnt;
        exp_q.push_back(8'h22);
        send_frame(8'h22, 1'b1, 1'b1, FRAME);
        serial_in = 1'b1;
        step(5);
        check("load_accept_valid", 32'(rx_valid), 1);
        check("load_accept_data",  32'(rx_data), 32'h22);
        check("load_accept_noerr", 32'(oerr_cnt), 32'(o0));
        check("load_sb_drained",   32'(exp_q.size()), 0);

        // Reset in the middle of data bit 4
        f0 = ferr_cnt; o0 = oerr_cnt;
        send_frame(8'h5A, 1'b1, 1'b0, 5 * CPB + CPB / 2);
        rst = 1'b1;
        #1;
        check("mid_rst_valid",   32'(rx_valid), 0);
        check("mid_rst_data",    32'(rx_data), 0);
        check("mid_rst_enable",  32'(tmr_enable), 0);
        check("mid_rst_rollval", 32'(tmr_rollover_val), CPB / 2);
        serial_in = 1'b1;
        step(3);
        rst = 1'b0;
        step(30);
        check("post_rst_no_err",   32'(ferr_cnt + oerr_cnt), 32'(f0 + o0));
        check("post_rst_no_valid", 32'(rx_valid), 0);
        exp_q.push_back(8'hF0);
        send_frame(8'hF0, 1'b1, 1'b0, FRAME);
        serial_in = 1'b1;
        step(5);
        check("f0_data", 32'(rx_data), 32'hF0);
        check("f0_sb_drained", 32'(exp_q.size()), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
